multi_core_cnn: RTL and testbench



---
 rtl/cnn_pkg.sv | 17 +
 rtl/cnn_core.sv | 96 +++++++++
 rtl/multi_core_cnn.sv | 33 +++
 tb/tb_multi_core_cnn.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and types for the multi-core 1-D CNN inference block.
package cnn_pkg;

  localparam int CONV_W = 36;
  localparam int TAPS   = 3;

  localparam logic signed [CONV_W-1:0] K0 = CONV_W'(1);
  localparam logic signed [CONV_W-1:0] K1 = CONV_W'(2);
  localparam logic signed [CONV_W-1:0] K2 = CONV_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } core_state_t;

endpackage

// File: rtl/cnn_core.sv
// One inference core: streams an image through a 3-tap conv, ReLU and sum-reduce.
//   state | meaning
//   IDLE  | in reset or waiting for the first edge after reset release
//   RUN   | reading one pixel per edge, accumulating once the window is full
//   DONE  | prediction latched, held until reset
module cnn_core
  import cnn_pkg::*;
#(
  parameter int img_size  = 64,
  parameter int out_width = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          image [img_size],
  output logic [out_width-1:0] prediction,
  output logic                 done
);

  // idx must reach img_size so RUN can spend one extra edge committing the result
  localparam int IW = $clog2(img_size + 1);
  localparam int AW = $clog2(img_size);
  localparam int SW = (out_width > CONV_W) ? out_width : CONV_W;

  core_state_t state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic signed [31:0]   x_m1_q, x_m1_d, x_m2_q, x_m2_d;
  logic [out_width-1:0] acc_q, acc_d, pred_q, pred_d;
  logic                 done_q, done_d;

  logic [AW-1:0]             rd_idx;
  logic signed [31:0]        x;
  logic signed [CONV_W-1:0]  e0, e1, e2, conv;
  logic [CONV_W-1:0]         relu;

  always_comb begin
    rd_idx = idx_q[AW-1:0];
    x      = image[rd_idx];
    e0     = x_m2_q;
    e1     = x_m1_q;
    e2     = x;
    conv   = K0 * e0 + K1 * e1 + K2 * e2;
    relu   = conv[CONV_W-1] ? '0 : conv;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_m1_d  = x_m1_q;
    x_m2_d  = x_m2_q;
    acc_d   = acc_q;
    pred_d  = pred_q;
    done_d  = done_q;
    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (idx_q == IW'(img_size)) begin
          state_d = DONE;
          pred_d  = acc_q;
          done_d  = 1'b1;
        end else begin
          x_m2_d = x_m1_q;
          x_m1_d = x;
          idx_d  = idx_q + IW'(1);
          if (idx_q >= IW'(TAPS - 1))
            acc_d = out_width'(SW'(acc_q) + SW'(relu));
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      x_m1_q  <= '0;
      x_m2_q  <= '0;
      acc_q   <= '0;
      pred_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_m1_q  <= x_m1_d;
      x_m2_q  <= x_m2_d;
      acc_q   <= acc_d;
      pred_q  <= pred_d;
      done_q  <= done_d;
    end
  end

  assign prediction = pred_q;
  assign done       = done_q;

endmodule

// File: rtl/multi_core_cnn.sv
// Top level: n independent CNN cores, one per staged image, plus a done AND-reduce.
module multi_core_cnn
  import cnn_pkg::*;
#(
  parameter int img_size  = 64,
  parameter int out_width = 32,
  parameter int n         = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          input_images [n][img_size],
  output logic [out_width-1:0] predictions [n],
  output logic                 all_done
);

  logic [n-1:0] done_vec;

  for (genvar g = 0; g < n; g++) begin : g_core
    cnn_core #(
      .img_size (img_size),
      .out_width(out_width)
    ) u_core (
      .clk       (clk),
      .rst       (rst),
      .image     (input_images[g]),
      .prediction(predictions[g]),
      .done      (done_vec[g])
    );
  end

  assign all_done = &done_vec;

endmodule

// File: tb/tb_multi_core_cnn.sv
// Randomized self-checking bench for multi_core_cnn against an arithmetic reference model.
module tb_multi_core_cnn;

  localparam int N  = 4;
  localparam int IS = 64;
  localparam int OW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   imgs [N][IS];
  logic [OW-1:0] predictions [N];
  logic          all_done;

  int tests_run = 0;
  int tests_failed = 0;

  multi_core_cnn #(.img_size(IS), .out_width(OW), .n(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .input_images(imgs),
    .predictions (predictions),
    .all_done    (all_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sum of ReLU'd 1-2-1 windows, done in wide integers and wrapped at the end.
  function automatic longint model(input int k);
    longint acc = 0;
    longint s;
    for (int p = 0; p <= IS - 3; p++) begin
      s = longint'($signed(imgs[k][p])) + 2 * longint'($signed(imgs[k][p+1]))
          + longint'($signed(imgs[k][p+2]));
      if (s > 0) acc += s;
    end
    return acc & 64'hFFFF_FFFF;
  endfunction

  task automatic fill_const(input logic [31:0] v);
    for (int k = 0; k < N; k++)
      for (int i = 0; i < IS; i++) imgs[k][i] = v;
  endtask

  task automatic fill_rand(input int mode);
    int v;
    for (int k = 0; k < N; k++)
      for (int i = 0; i < IS; i++) begin
        if (mode == 0) v = int'($urandom);
        else v = int'($urandom_range(0, 200)) - 100;
        imgs[k][i] = v;
      end
  endtask

  task automatic check_cleared(input string tag);
    check_val({tag, "_all_done_rst"}, longint'(all_done), 0);
    for (int k = 0; k < N; k++)
      check_val($sformatf("%s_pred%0d_rst", tag, k), longint'(predictions[k]), 0);
  endtask

  task automatic wait_done(input string tag);
    int e = -1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (all_done) begin
        e = i;
        break;
      end
    end
    check_val({tag, "_done_edge"}, longint'(e), 65);
    for (int k = 0; k < N; k++)
      check_val($sformatf("%s_pred%0d", tag, k), longint'(predictions[k]), model(k));
  endtask

  task automatic run_set(input string tag);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_cleared(tag);
    rst = 1'b1;
    wait_done(tag);
  endtask

  initial begin
    logic [OW-1:0] held [N];
    fill_const(32'd1);

    run_set("ones");

    for (int i = 0; i < IS; i++) imgs[0][i] = i;
    run_set("ramp");

    fill_const(32'hFFFF_FFFF);
    run_set("neg");

    fill_const(32'h7FFF_FFFF);
    run_set("wrap");

    fill_rand(0);
    run_set("rand_full");
    fill_rand(1);
    run_set("rand_small_a");
    fill_rand(1);
    run_set("rand_small_b");

    // Reset in the middle of a run, then a full restart.
    fill_const(32'd1);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 32; i++) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_cleared($sformatf("midrst%0d", c));
    end
    @(negedge clk); rst = 1'b1;
    wait_done("midrst_restart");

    // Inputs changing while in DONE must not disturb the held results.
    for (int k = 0; k < N; k++) held[k] = predictions[k];
    fill_rand(0);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check_val($sformatf("hold_done%0d", c), longint'(all_done), 1);
    end
    for (int k = 0; k < N; k++)
      check_val($sformatf("hold_pred%0d", k), longint'(predictions[k]), longint'(held[k]));

    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check_cleared("final");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
